// File: rtl/reset_ctrl_pkg.sv
// Shared types and helpers for the reset_ctrl run-control stage.
package reset_ctrl_pkg;

    localparam int unsigned STAGES_MAX = 8;
    localparam int unsigned IDX_W      = $clog2(STAGES_MAX);

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_DONE    = 3'd4,
        ST_TIMEOUT = 3'd5
    } state_e;

    // Counter width able to hold 0..limit, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset deassertion synchroniser: set asynchronously, released through SYNC_DEPTH flops.
module reset_sync #(
    parameter int unsigned SYNC_DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    output logic rst_sync
);

    logic [SYNC_DEPTH-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '1;
        end else begin
            chain <= {chain[SYNC_DEPTH-2:0], 1'b0};
        end
    end

    assign rst_sync = chain[SYNC_DEPTH-1];

endmodule

// File: rtl/reset_ctrl.sv
// Staged reset release with done handshake; watchdog present when RESET_CTRL_WATCHDOG_EN is defined.
module reset_ctrl
    import reset_ctrl_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES    = 4,
    parameter int unsigned STAGES         = 2,
    parameter int unsigned STAGE_GAP      = 1,
    parameter int unsigned SYNC_DEPTH     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sw_reset_req,
    input  logic              done,
    output logic [STAGES-1:0] reset_l_o,
    output logic              running,
    output logic              timeout
);

    localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES);
    localparam int unsigned GAP_W  = cnt_width(STAGE_GAP);

    if (HOLD_CYCLES < 1 || STAGES < 1 || STAGES > STAGES_MAX ||
        SYNC_DEPTH < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("reset_ctrl: illegal parameter value");
    end

    logic              rst_sync;
    state_e            state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
    logic [IDX_W-1:0]  stage_idx, stage_idx_nxt;
    logic [STAGES-1:0] reset_l_nxt;

`ifdef RESET_CTRL_WATCHDOG_EN
    localparam int unsigned WD_W = cnt_width(TIMEOUT_CYCLES);
    logic [WD_W-1:0] wd_cnt, wd_cnt_nxt;
`endif

    reset_sync #(.SYNC_DEPTH(SYNC_DEPTH)) u_sync (
        .clk      (clk),
        .reset    (reset),
        .rst_sync (rst_sync)
    );

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RESET;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            stage_idx <= '0;
            reset_l_o <= '0;
            running   <= 1'b0;
`ifdef RESET_CTRL_WATCHDOG_EN
            wd_cnt    <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_cnt_nxt;
            gap_cnt   <= gap_cnt_nxt;
            stage_idx <= stage_idx_nxt;
            reset_l_o <= reset_l_nxt;
            running   <= (state_nxt == ST_RUN);
`ifdef RESET_CTRL_WATCHDOG_EN
            wd_cnt    <= wd_cnt_nxt;
            timeout   <= (state_nxt == ST_TIMEOUT);
`endif
        end
    end

`ifndef RESET_CTRL_WATCHDOG_EN
    assign timeout = 1'b0;
`endif

    // Next state, counters and reset outputs.
    always_comb begin
        state_nxt     = state;
        hold_cnt_nxt  = hold_cnt;
        gap_cnt_nxt   = gap_cnt;
        stage_idx_nxt = stage_idx;
        reset_l_nxt   = reset_l_o;
`ifdef RESET_CTRL_WATCHDOG_EN
        wd_cnt_nxt    = wd_cnt;
`endif

        if (state != ST_RESET && sw_reset_req) begin
            state_nxt    = ST_HOLD;
            hold_cnt_nxt = '0;
            reset_l_nxt  = '0;
        end else begin
            case (state)
                ST_RESET: begin
                    reset_l_nxt = '0;
                    if (!rst_sync) begin
                        state_nxt    = ST_HOLD;
                        hold_cnt_nxt = '0;
                    end
                end
                ST_HOLD: begin
                    reset_l_nxt = '0;
                    if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                        reset_l_nxt   = STAGES'(1);
                        stage_idx_nxt = '0;
                        gap_cnt_nxt   = '0;
                        if (STAGES == 1) begin
                            state_nxt = ST_RUN;
`ifdef RESET_CTRL_WATCHDOG_EN
                            wd_cnt_nxt = '0;
`endif
                        end else begin
                            state_nxt = ST_RELEASE;
                        end
                    end else begin
                        hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                    end
                end
                ST_RELEASE: begin
                    // Stages release in order, so the release mask is a thermometer code.
                    if (gap_cnt == GAP_W'(STAGE_GAP)) begin
                        gap_cnt_nxt   = '0;
                        stage_idx_nxt = stage_idx + IDX_W'(1);
                        reset_l_nxt   = (reset_l_o << 1) | STAGES'(1);
                        if (stage_idx + IDX_W'(1) == IDX_W'(STAGES - 1)) begin
                            state_nxt = ST_RUN;
`ifdef RESET_CTRL_WATCHDOG_EN
                            wd_cnt_nxt = '0;
`endif
                        end
                    end else begin
                        gap_cnt_nxt = gap_cnt + GAP_W'(1);
                    end
                end
                ST_RUN: begin
                    if (done) begin
                        state_nxt = ST_DONE;
`ifdef RESET_CTRL_WATCHDOG_EN
                    end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        state_nxt   = ST_TIMEOUT;
                        reset_l_nxt = '0;
                    end else begin
                        wd_cnt_nxt = wd_cnt + WD_W'(1);
`endif
                    end
                end
                ST_DONE:    state_nxt = ST_DONE;
                ST_TIMEOUT: state_nxt = ST_TIMEOUT;
                default: begin
                    state_nxt   = ST_RESET;
                    reset_l_nxt = '0;
                end
            endcase
        end
    end

endmodule

// File: doc/reset_ctrl.md
# reset_ctrl

Run-control stage that sits directly upstream of the example counter submodules. It turns one asynchronous, active-high reset into staged, synchronised, active-low `reset_l` releases, one per downstream stage. It then supervises the run through a `done` handshake and a watchdog. A downstream block that never reports completion is forced back into reset and flagged.

## Interface
- `HOLD_CYCLES`, 4: cycles all outputs stay in reset after synchronised deassertion; ≥1
- `STAGES`, 2: number of `reset_l_o` bits; 1..8; bit 0 releases first
- `STAGE_GAP`, 1: idle cycles between consecutive stage releases; ≥0
- `SYNC_DEPTH`, 2: deassertion synchroniser flops; ≥2
- `TIMEOUT_CYCLES`, 100: watchdog limit in RUN; ≥1
- `clk`  in  1  single clock; all state on posedge
- `reset`  in  1  asynchronous, active-high reset
- `sw_reset_req`  in  1  single-cycle request to re-run the reset sequence
- `done`  in  1  completion pulse from downstream; sampled only in RUN
- `reset_l_o`  out  STAGES  active-low resets to downstream stages
- `running`  out  1  high while in RUN
- `timeout`  out  1  sticky watchdog expiry flag

## Operation
- Asserting `reset` immediately and asynchronously forces the following, with no clock edge needed:
  - `reset_l_o` = all 0
  - `running` = 0
  - `timeout` = 0
  - FSM = RESET
  - synchroniser chain = all 1
- Deassertion of `reset` passes through `SYNC_DEPTH` flops before the FSM sees it. All outputs are registered.
- FSM states:
  - RESET: while the synchronised reset is high. Leaves for HOLD once it is low, clearing the hold counter.
  - HOLD: `reset_l_o` is all 0. The counter increments each cycle. After `HOLD_CYCLES` cycles, go to RELEASE and set stage index = 0.
  - RELEASE: on entry, set `reset_l_o[0]`. Each further stage k is set k*(STAGE_GAP+1) cycles after stage 0. Bits, once set, stay set. On the edge that sets bit STAGES-1, go to RUN, set `running` = 1 and clear the watchdog.
  - RUN:
    - `done` high → DONE.
    - Watchdog reaches `TIMEOUT_CYCLES` → TIMEOUT.
  - DONE: `running` = 0; `reset_l_o` stays all 1. Sticky.
  - TIMEOUT: `timeout` = 1, `running` = 0, `reset_l_o` = all 0. Sticky.
- `sw_reset_req` in HOLD, RELEASE, RUN, DONE or TIMEOUT has these effects on the next edge:
  - `reset_l_o` = 0, `running` = 0, `timeout` = 0
  - FSM goes to HOLD with the counter cleared
  - In RESET the request is ignored.
- Priority on the same edge: `reset` > `sw_reset_req` > `done` > watchdog expiry.
- `done` is ignored outside RUN.
- Counter widths are `$clog2(limit+1)`. Counters never wrap: each saturates at its terminal value, then the state changes.

## Timing
- Edge numbering: the first posedge with `reset` low is edge 1.
- Synchronised reset falls at edge `SYNC_DEPTH`. HOLD is entered at edge `SYNC_DEPTH+1`.
- `reset_l_o[0]` rises at edge `SYNC_DEPTH+1+HOLD_CYCLES`; with defaults, edge 7.
- `reset_l_o[k]` rises (STAGE_GAP+1)*k edges later; with defaults, bit 1 at edge 9. `running` rises on the same edge.
- With STAGES=1, `running` rises together with bit 0.
- `done` sampled high at edge n of RUN → `running` = 0 at edge n+1.
- Watchdog: RUN entered at edge r → `timeout` = 1 and `reset_l_o` = 0 at edge r+TIMEOUT_CYCLES, unless `done` was sampled earlier.
- `sw_reset_req` at edge s → outputs low at s+1; bit 0 rises at s+1+HOLD_CYCLES.

## Configuration
- `RESET_CTRL_WATCHDOG_EN` defined: watchdog counter and TIMEOUT state are present, as described above.
- Undefined:
  - no watchdog logic
  - `timeout` tied 0
  - RUN exits only via `done`, `sw_reset_req` or `reset`
  - `TIMEOUT_CYCLES` unused

## Structure
- `reset_ctrl_pkg`: FSM state enum (RESET, HOLD, RELEASE, RUN, DONE, TIMEOUT), 3-bit encoding; shared `STAGES_MAX` = 8.
- One sub-module, `reset_sync`: `SYNC_DEPTH`-flop chain, asynchronously set by `reset` and shifting 0 in on deassertion. Its output drives the FSM.

## Test plan
- Power-on, defaults: `reset` high 3 cycles then low → `reset_l_o` = 2'b00 through edge 6, 2'b01 at edge 7, 2'b11 at edge 9; `running` = 1 at edge 9.
- `done` pulse 5 cycles after `running` → `running` = 0 next edge; `reset_l_o` stays 2'b11; `timeout` stays 0 for 300 cycles.
- Watchdog on, no `done` → `timeout` = 1 and `reset_l_o` = 2'b00 at edge 109; both hold for 200 cycles; a later `done` pulse is ignored.
- `sw_reset_req` pulse in RUN → `reset_l_o` = 2'b00 next edge; bit 0 rises 4 edges after that, bit 1 2 edges later; `timeout` cleared.
- `reset` asserted between edges during RELEASE → `reset_l_o` = 0 before the next edge; the sequence restarts with bit 0 again 7 edges after the next deassertion.
- `sw_reset_req` and `done` high on the same RUN edge → HOLD wins and `running` = 0. With the macro undefined and no `done`, `timeout` = 0 and `running` = 1 after 1000 cycles.
